// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor: per-neighbour liveness tracking.
// Issues one heartbeat request per neighbour each period.
module heartbeat_monitor #(
  parameter int NUM_NEIGHBORS = 4,
  parameter int ID_WIDTH      = $clog2(NUM_NEIGHBORS),
  parameter int PERIOD_CYCLES = 256,
  parameter int MISS_LIMIT    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [ID_WIDTH-1:0]      req_neighbor,
  input  logic                     rsp_valid,
  input  logic [ID_WIDTH-1:0]      rsp_neighbor,
  output logic [NUM_NEIGHBORS-1:0] alive,
  output logic [NUM_NEIGHBORS-1:0] link_up,
  output logic [NUM_NEIGHBORS-1:0] link_down,
  output logic                     overrun
);

  localparam int TW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(PERIOD_CYCLES - 1);
  localparam logic [ID_WIDTH-1:0] ILAST = ID_WIDTH'(NUM_NEIGHBORS - 1);
  localparam logic [3:0] MLIM = 4'(MISS_LIMIT);

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [TW-1:0]           r_timer;
  logic [ID_WIDTH-1:0]     r_idx;
  logic [ID_WIDTH-1:0]     w_idx_nxt;
  logic                    r_req_valid;
  logic                    w_req_valid_nxt;
  logic                    r_overrun;
  logic                    w_overrun_nxt;
  logic                    w_expiry;

  logic [NUM_NEIGHBORS-1:0] r_seen;
  logic [NUM_NEIGHBORS-1:0] r_alive;
  logic [NUM_NEIGHBORS-1:0] r_link_up;
  logic [NUM_NEIGHBORS-1:0] r_link_down;
  logic [NUM_NEIGHBORS-1:0] w_hit;
  logic [NUM_NEIGHBORS-1:0] w_seen_nxt;
  logic [NUM_NEIGHBORS-1:0] w_alive_nxt;
  logic [NUM_NEIGHBORS-1:0] w_up_nxt;
  logic [NUM_NEIGHBORS-1:0] w_down_nxt;
  logic [3:0]               r_miss     [NUM_NEIGHBORS];
  logic [3:0]               w_miss_nxt [NUM_NEIGHBORS];

  assign w_expiry     = enable && (r_timer == TLAST);
  assign req_valid    = r_req_valid;
  assign req_neighbor = r_idx;
  assign overrun      = r_overrun;
  assign alive        = r_alive;
  assign link_up      = r_link_up;
  assign link_down    = r_link_down;

  // Period timer: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (!enable || w_expiry) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Round sequencer: a request is never retracted until accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      S_IDLE: begin
        if (w_expiry) begin
          w_state_nxt = S_ISSUE;
          w_idx_nxt   = '0;
        end
      end
      S_ISSUE: begin
        if (req_ready) begin
          if (r_idx == ILAST || !enable) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
    endcase
    w_req_valid_nxt = (w_state_nxt == S_ISSUE);
    w_overrun_nxt   = w_expiry && (r_state == S_ISSUE);
  end

  // Sequencer registers, including the registered request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_req_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  // Per-neighbour liveness: a same-cycle response counts for the closing period.
  always_comb begin
    for (int n = 0; n < NUM_NEIGHBORS; n++) begin
      w_hit[n]       = rsp_valid && (rsp_neighbor == ID_WIDTH'(n));
      w_seen_nxt[n]  = r_seen[n];
      w_alive_nxt[n] = r_alive[n];
      w_up_nxt[n]    = 1'b0;
      w_down_nxt[n]  = 1'b0;
      w_miss_nxt[n]  = r_miss[n];
      if (w_hit[n] && !r_alive[n]) begin
        w_alive_nxt[n] = 1'b1;
        w_up_nxt[n]    = 1'b1;
        w_miss_nxt[n]  = '0;
      end
      if (w_expiry) begin
        w_seen_nxt[n] = 1'b0;
        if (r_seen[n] || w_hit[n]) begin
          w_miss_nxt[n] = '0;
        end else begin
          w_miss_nxt[n] = (r_miss[n] == MLIM) ? MLIM : r_miss[n] + 4'd1;
          if (w_miss_nxt[n] == MLIM && r_alive[n]) begin
            w_alive_nxt[n] = 1'b0;
            w_down_nxt[n]  = 1'b1;
          end
        end
      end else if (w_hit[n]) begin
        w_seen_nxt[n] = 1'b1;
      end
    end
  end

  // Liveness registers and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seen      <= '0;
      r_alive     <= '0;
      r_link_up   <= '0;
      r_link_down <= '0;
      for (int n = 0; n < NUM_NEIGHBORS; n++) begin
        r_miss[n] <= '0;
      end
    end else begin
      r_seen      <= w_seen_nxt;
      r_alive     <= w_alive_nxt;
      r_link_up   <= w_up_nxt;
      r_link_down <= w_down_nxt;
      for (int n = 0; n < NUM_NEIGHBORS; n++) begin
        r_miss[n] <= w_miss_nxt[n];
      end
    end
  end

endmodule

// File: tb/tb_heartbeat_monitor.sv
// tb_heartbeat_monitor: directed + random bench
// against a queue-based reference model.
module tb_heartbeat_monitor;

  localparam int N  = 4;
  localparam int IW = 3;
  localparam int P  = 16;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_neighbor;
  logic          rsp_valid;
  logic [IW-1:0] rsp_neighbor;
  logic [N-1:0]  alive;
  logic [N-1:0]  link_up;
  logic [N-1:0]  link_down;
  logic          overrun;

  heartbeat_monitor #(
    .NUM_NEIGHBORS(N),
    .ID_WIDTH     (IW),
    .PERIOD_CYCLES(P),
    .MISS_LIMIT   (L)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_neighbor(req_neighbor),
    .rsp_valid   (rsp_valid),
    .rsp_neighbor(rsp_neighbor),
    .alive       (alive),
    .link_up     (link_up),
    .link_down   (link_down),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_tmr;
  int          q[$];
  logic [N-1:0] m_seen;
  logic [N-1:0] m_alive;
  logic [N-1:0] m_up;
  logic [N-1:0] m_down;
  int          m_miss[N];
  logic        m_ovr;
  logic        m_exp;

  function automatic void model_reset();
    m_tmr   = 0;
    q.delete();
    m_seen  = '0;
    m_alive = '0;
    m_up    = '0;
    m_down  = '0;
    m_ovr   = 1'b0;
    m_exp   = 1'b0;
    for (int n = 0; n < N; n++) m_miss[n] = 0;
  endfunction

  function automatic void model_step();
    logic ex, busy, hit, was;
    ex    = enable && (m_tmr == P - 1);
    busy  = (q.size() > 0);
    m_exp = ex;
    m_ovr = ex && busy;
    if (busy && req_ready) begin
      void'(q.pop_front());
      if (!enable) q.delete();
    end
    if (ex && !busy)
      for (int i = 0; i < N; i++) q.push_back(i);
    m_tmr  = enable ? (m_tmr + 1) % P : 0;
    m_up   = '0;
    m_down = '0;
    for (int n = 0; n < N; n++) begin
      hit = rsp_valid && (int'(rsp_neighbor) < N)
            && (int'(rsp_neighbor) == n);
      was = m_seen[n];
      if (hit) begin
        m_seen[n] = 1'b1;
        if (!m_alive[n]) begin
          m_alive[n] = 1'b1;
          m_up[n]    = 1'b1;
          m_miss[n]  = 0;
        end
      end
      if (ex) begin
        if (was || hit) m_miss[n] = 0;
        else if (m_miss[n] + 1 > L) m_miss[n] = L;
        else m_miss[n] = m_miss[n] + 1;
        if (m_miss[n] == L && m_alive[n]) begin
          m_alive[n] = 1'b0;
          m_down[n]  = 1'b1;
        end
        m_seen[n] = 1'b0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    int nb;
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    nb = (q.size() > 0) ? q[0] : 0;
    chk("m_req_valid", req_valid, q.size() > 0);
    chk("m_req_nb", req_neighbor, nb);
    chk("m_alive", alive, m_alive);
    chk("m_link_up", link_up, m_up);
    chk("m_link_down", link_down, m_down);
    chk("m_overrun", overrun, m_ovr);
  endtask

  task automatic wait_tmr(input int t);
    for (int i = 0; i < P + 2; i++) begin
      if (m_tmr == t) break;
      cyc();
    end
    chk("wait_tmr", m_tmr, t);
  endtask

  task automatic pulse_rsp(input int id);
    rsp_valid    = 1'b1;
    rsp_neighbor = IW'(id);
    cyc();
    rsp_valid    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    int   ids[$];
    logic got;
    logic saw;
    logic [N-1:0] a_save;

    rst          = 1'b1;
    enable       = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_neighbor = '0;
    model_reset();

    // reset / idle
    saw = 1'b0;
    repeat (50) begin
      cyc();
      saw = saw | req_valid;
    end
    chk("idle_no_valid", saw, 0);
    rst = 1'b0;

    // round issue
    enable    = 1'b1;
    req_ready = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      logic ev;
      cyc();
      ev = (k >= 16 && k <= 19) || (k >= 32 && k <= 35);
      chk("round_valid", req_valid, ev);
      if (ev) chk("round_id", req_neighbor, (k - 16) % 16);
    end

    // backpressure / overrun
    req_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (req_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("bp_first_valid", got, 1);
    cnt = 0;
    repeat (20) begin
      cyc();
      chk("bp_hold_valid", req_valid, 1);
      chk("bp_hold_id", req_neighbor, 0);
      if (overrun) cnt++;
    end
    chk("bp_overrun_once", cnt, 1);
    req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!req_valid) break;
      ids.push_back(int'(req_neighbor));
      cyc();
    end
    chk("bp_round_len", ids.size(), 4);
    for (int i = 0; i < ids.size(); i++) chk("bp_round_id", ids[i], i);
    repeat (4) begin
      cyc();
      chk("bp_no_extra", req_valid, 0);
    end

    // link up / down for neighbour 2
    wait_tmr(3);
    pulse_rsp(2);
    chk("up2_pulse", link_up, 4'b0100);
    chk("up2_alive", alive[2], 1);
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      cyc();
      if (m_exp) cnt++;
      if (link_down != '0) begin
        got = 1'b1;
        break;
      end
    end
    chk("down2_seen", got, 1);
    chk("down2_pulse", link_down, 4'b0100);
    chk("down2_expiries", cnt, 4);
    chk("down2_alive", alive[2], 0);

    // responses exactly on the expiry cycle keep neighbour 1 alive
    wait_tmr(3);
    pulse_rsp(1);
    chk("up1_pulse", link_up, 4'b0010);
    repeat (3) begin
      wait_tmr(P - 1);
      pulse_rsp(1);
      chk("edge1_no_down", link_down[1], 0);
      chk("edge1_alive", alive[1], 1);
    end
    wait_tmr(P - 1);
    pulse_rsp(3);
    chk("edge3_up", link_up, 4'b1000);

    // out-of-range id
    a_save = alive;
    pulse_rsp(5);
    chk("oor_no_up", link_up, 0);
    chk("oor_alive", alive, a_save);

    // random traffic
    repeat (700) begin
      enable       = ($urandom_range(0, 19) != 0);
      req_ready    = ($urandom_range(0, 9) < 7);
      rsp_valid    = ($urandom_range(0, 9) < 2);
      rsp_neighbor = IW'($urandom_range(0, 7));
      cyc();
    end
    enable    = 1'b1;
    req_ready = 1'b1;
    rsp_valid = 1'b0;

    // reset mid-round
    pulse_rsp(0);
    chk("pre_rst_alive", alive[0], 1);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (req_valid && req_neighbor == 2) begin
        got = 1'b1;
        break;
      end
    end
    chk("rst_at_id2", got, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", req_valid, 0);
    chk("rst_async_alive", alive, 0);
    chk("rst_async_id", req_neighbor, 0);
    repeat (3) cyc();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      cnt++;
      if (req_valid) break;
    end
    chk("rst_first_req", cnt, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
